// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: FSM encoding, default fixed-point formats
// and the accumulator sizing rule.
package nn_pkg;

    localparam int unsigned DefFracW   = 10;
    localparam int unsigned DefOutFrac = 4;

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StFin,
        StOut
    } state_e;

    // Full product width plus headroom for N_MAX products and the bias.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned n_max);
        return 2 * data_w + $clog2(n_max) + 1;
    endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Fixed-point narrowing: arithmetic right shift with round-half-up, then clip to OUT_W
// signed bits, with an optional clamp of negative results to zero.
module fx_round_sat #(
    parameter int unsigned IN_W  = 37,
    parameter int unsigned SHIFT = 16,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned RELU  = 0
) (
    input  logic [IN_W-1:0]  acc_i,
    output logic [OUT_W-1:0] z_o,
    output logic             sat_o
);

    logic signed [IN_W:0]        acc_ext;
    logic signed [IN_W:0]        rnd;
    logic signed [IN_W:0]        sum;
    logic signed [IN_W:0]        shifted;
    logic        [IN_W-OUT_W+1:0] upper;

    assign acc_ext = {acc_i[IN_W-1], acc_i};

    if (SHIFT > 0) begin : g_rnd
        assign rnd = (IN_W + 1)'(1) << (SHIFT - 1);
    end else begin : g_no_rnd
        assign rnd = '0;
    end

    assign sum     = acc_ext + rnd;
    assign shifted = sum >>> SHIFT;
    // Result fits iff every bit from the output sign bit upward matches.
    assign upper   = shifted[IN_W:OUT_W-1];

    always_comb begin
        z_o   = shifted[OUT_W-1:0];
        sat_o = 1'b0;
        if ((RELU != 0) && shifted[IN_W]) begin
            z_o = '0;
        end else if (!shifted[IN_W] && (|upper)) begin
            z_o   = {1'b0, {(OUT_W-1){1'b1}}};
            sat_o = 1'b1;
        end else if (shifted[IN_W] && !(&upper)) begin
            z_o   = {1'b1, {(OUT_W-1){1'b0}}};
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: bias plus streamed k*w products, narrowed to a
// saturated fixed-point result held until the consumer accepts it.
module neuron_mac
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned FRAC_W   = DefFracW,
    parameter int unsigned N_MAX    = 16,
    parameter int unsigned OUT_W    = 8,
    parameter int unsigned OUT_FRAC = DefOutFrac,
    parameter int unsigned RELU     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(N_MAX+1)-1:0] n,
    input  logic [DATA_W-1:0]          b,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          k,
    input  logic [DATA_W-1:0]          w,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           z,
    output logic                       sat,
    output logic                       busy
);

    localparam int unsigned CntW  = $clog2(N_MAX + 1);
    localparam int unsigned AccW  = acc_width(DATA_W, N_MAX);
    localparam int unsigned Shift = 2 * FRAC_W - OUT_FRAC;

    state_e                   state_q, state_d;
    logic signed [AccW-1:0]   acc_q, acc_d;
    logic        [CntW-1:0]   cnt_q, cnt_d;
    logic        [OUT_W-1:0]  z_q, z_d;
    logic                     sat_q, sat_d;

    logic signed [AccW-1:0]     bias_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [AccW-1:0]     prod_ext;
    logic        [OUT_W-1:0]    conv_z;
    logic                       conv_sat;

    assign bias_ext = {{(AccW-DATA_W){b[DATA_W-1]}}, b};
    assign prod     = $signed(k) * $signed(w);
    assign prod_ext = {{(AccW-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    fx_round_sat #(
        .IN_W  (AccW),
        .SHIFT (Shift),
        .OUT_W (OUT_W),
        .RELU  (RELU)
    ) u_round_sat (
        .acc_i (acc_q),
        .z_o   (conv_z),
        .sat_o (conv_sat)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        sat_d   = sat_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = bias_ext <<< FRAC_W;
                    cnt_d   = n;
                    state_d = (n == '0) ? StFin : StAcc;
                end
            end
            StAcc: begin
                if (in_valid) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                z_d     = conv_z;
                sat_d   = conv_sat;
                state_d = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready  = (state_q == StAcc);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign z         = z_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: a plain-arithmetic model predicts every result, checked
// each cycle out_valid is high, alongside hand-computed literals for each scenario.
module tb_neuron_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, in_valid, out_ready;
    logic [4:0]  n;
    logic [15:0] b, k, w;
    logic        in_ready, out_valid, sat, busy;
    logic [7:0]  z;
    logic        in_ready_r, out_valid_r, sat_r, busy_r;
    logic [7:0]  z_r;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int delivered = 0;
    int expected_cnt = 0;

    logic [7:0]  exp_z[$];
    logic [7:0]  exp_zr[$];
    bit          exp_sat[$];
    bit          exp_satr[$];
    logic [15:0] kv[3];
    logic [15:0] wv[3];

    neuron_mac #(.RELU(0)) dut (
        .clk(clk), .reset(reset), .start(start), .n(n), .b(b),
        .in_valid(in_valid), .in_ready(in_ready), .k(k), .w(w),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .sat(sat), .busy(busy)
    );

    neuron_mac #(.RELU(1)) dut_relu (
        .clk(clk), .reset(reset), .start(start), .n(n), .b(b),
        .in_valid(in_valid), .in_ready(in_ready_r), .k(k), .w(w),
        .out_valid(out_valid_r), .out_ready(out_ready), .z(z_r), .sat(sat_r), .busy(busy_r)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Real-valued result in units of 2^-20, rounded half up to 2^-4, then clipped.
    function automatic void model(input logic [15:0] bb, input int nn, input bit relu,
                                  output logic [7:0] zz, output bit ss);
        longint acc;
        longint q;
        acc = longint'($signed(bb)) * 1024;
        for (int i = 0; i < nn; i++) begin
            acc += longint'($signed(kv[i])) * longint'($signed(wv[i]));
        end
        acc += 32768;
        q = acc / 65536;
        if (acc < 0 && q * 65536 != acc) q -= 1;
        ss = 1'b0;
        if (relu && q < 0) begin
            q = 0;
        end else if (q > 127) begin
            q  = 127;
            ss = 1'b1;
        end else if (q < -128) begin
            q  = -128;
            ss = 1'b1;
        end
        zz = q[7:0];
    endfunction

    always @(negedge clk) begin
        if (!reset && (out_valid || out_valid_r)) begin
            check("valid_pair", out_valid_r, out_valid);
            if (exp_z.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: out_valid=1 z=0x%0h, required no result", z);
            end else begin
                check("z", z, exp_z[0]);
                check("sat", sat, exp_sat[0]);
                check("z_relu", z_r, exp_zr[0]);
                check("sat_relu", sat_r, exp_satr[0]);
                if (out_ready && out_valid) begin
                    void'(exp_z.pop_front());
                    void'(exp_sat.pop_front());
                    void'(exp_zr.pop_front());
                    void'(exp_satr.pop_front());
                    delivered++;
                end
            end
        end
    end

    task automatic send_beat(input logic [15:0] kk, input logic [15:0] ww, output int edge_c);
        int tmo;
        bit got;
        tmo = 0;
        got = 1'b0;
        in_valid = 1'b1;
        k = kk;
        w = ww;
        while (!got && tmo < 20) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            tmo++;
        end
        check("beat_accept", got, 1);
        edge_c = cyc;
        in_valid = 1'b0;
    endtask

    task automatic do_eval(input int nn, input logic [15:0] bb, input int gap, input int hold,
                           input bit pulse, input logic [7:0] lz, input bit ls,
                           input logic [7:0] lzr, input bit lsr);
        int last;
        int tmo;
        bit seen;
        bit saw_ready;
        logic [7:0] mz;
        bit ms;
        model(bb, nn, 1'b0, mz, ms);
        exp_z.push_back(mz);
        exp_sat.push_back(ms);
        model(bb, nn, 1'b1, mz, ms);
        exp_zr.push_back(mz);
        exp_satr.push_back(ms);
        expected_cnt++;
        start = 1'b1;
        n = nn[4:0];
        b = bb;
        @(posedge clk);
        #1;
        start = 1'b0;
        last = cyc;
        for (int i = 0; i < nn; i++) begin
            send_beat(kv[i], wv[i], last);
            if (i != nn - 1) repeat (gap) begin @(posedge clk); #1; end
        end
        seen = 1'b0;
        saw_ready = 1'b0;
        tmo = 0;
        while (!seen && tmo < 20) begin
            @(negedge clk);
            if (in_ready) saw_ready = 1'b1;
            seen = out_valid;
            if (!seen) begin
                @(posedge clk);
                tmo++;
            end
        end
        check("out_valid_seen", seen, 1);
        check("latency", cyc - last, 1);
        if (nn == 0) check("no_in_ready", saw_ready, 0);
        check("lit_z", z, lz);
        check("lit_sat", sat, ls);
        check("lit_z_relu", z_r, lzr);
        check("lit_sat_relu", sat_r, lsr);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            start = pulse && (h == 1);
            n = 5'd2;
            b = 16'h0400;
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_out", busy, 0);
        check("valid_drop", out_valid, 0);
    endtask

    initial begin
        int last;
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n = '0;
        b = '0;
        k = '0;
        w = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_z", z, 0);
        check("rst_sat", sat, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);

        // -1.0 + 8*0.0996 + 8*0.3994 = 2.99 -> 0x30
        kv[0] = 16'h2000; wv[0] = 16'h0066;
        kv[1] = 16'h2000; wv[1] = 16'h0199;
        do_eval(2, 16'hFC00, 0, 0, 1'b0, 8'h30, 1'b0, 8'h30, 1'b0);

        kv[0] = 16'h2000; wv[0] = 16'h2000;
        do_eval(1, 16'h0000, 0, 0, 1'b0, 8'h7F, 1'b1, 8'h7F, 1'b1);
        wv[0] = 16'hE000;
        do_eval(1, 16'h0000, 0, 0, 1'b0, 8'h80, 1'b1, 8'h00, 1'b0);

        do_eval(0, 16'h0800, 0, 0, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0);

        // -1.5 -> -24
        kv[0] = 16'h0400; wv[0] = 16'hFA00;
        do_eval(1, 16'h0000, 0, 0, 1'b0, 8'hE8, 1'b0, 8'h00, 1'b0);

        // Exact half LSB: +1/32 rounds up to 1, -1/32 rounds up to 0.
        kv[0] = 16'h0020; wv[0] = 16'h0400;
        do_eval(1, 16'h0000, 0, 0, 1'b0, 8'h01, 1'b0, 8'h01, 1'b0);
        kv[0] = 16'hFFE0;
        do_eval(1, 16'h0000, 0, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // 0.5 + 1 + 0.5 - 0.5 = 1.5 -> 0x18
        kv[0] = 16'h0400; wv[0] = 16'h0400;
        kv[1] = 16'h0400; wv[1] = 16'h0200;
        kv[2] = 16'h0400; wv[2] = 16'hFE00;
        do_eval(3, 16'h0200, 1, 0, 1'b0, 8'h18, 1'b0, 8'h18, 1'b0);

        // Backpressure with gapped beats and a start pulse while busy.
        kv[0] = 16'h2000; wv[0] = 16'h0066;
        kv[1] = 16'h2000; wv[1] = 16'h0199;
        do_eval(2, 16'hFC00, 2, 4, 1'b1, 8'h30, 1'b0, 8'h30, 1'b0);

        // Abort after one of three beats.
        start = 1'b1;
        n = 5'd3;
        b = 16'h1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_beat(16'h2000, 16'h2000, last);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_out_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_in_ready", in_ready, 0);
        end
        kv[0] = 16'h0400; wv[0] = 16'h0400;
        do_eval(1, 16'h0400, 0, 0, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0);

        repeat (5) @(negedge clk);
        check("delivered", delivered, expected_cnt);
        check("pending_results", exp_z.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
